// File: rtl/xsim_run_control.sv
// xsim_run_control: reset synchronizer/stretcher and finish-request quiesce/drain sequencer.
// Ports: CLK, RST_N (async active-low) in; finish_req, idle_in in;
//        rst_n_out, quiesce, finish_out, drain_forced, timed_out out; cycle_count, state out.
// Optional watchdog enabled by defining XSIM_RUN_CONTROL_TIMEOUT_EN.
module xsim_run_control #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 20,
    parameter int DRAIN_CYCLES   = 16,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 finish_req,
    input  logic                 idle_in,
    output logic                 rst_n_out,
    output logic                 quiesce,
    output logic                 finish_out,
    output logic                 drain_forced,
    output logic                 timed_out,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [2:0]           state
);
    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_HOLD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_rst_n;
    logic [31:0]            hold_cnt_q, hold_cnt_d, drain_cnt_q, drain_cnt_d;
    logic                   pending_q, pending_d, forced_q, forced_d, tout_q, tout_d;
    logic [CNT_WIDTH-1:0]   cyc_q, cyc_d;
    logic                   wd_fire;

    assign sync_rst_n = sync_q[SYNC_STAGES-1];

`ifdef XSIM_RUN_CONTROL_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] run_cnt_q;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) run_cnt_q <= '0;
        else        run_cnt_q <= (state_q == S_RUN) ? run_cnt_q + 32'd1 : '0;
    end
    assign wd_fire = (state_q == S_RUN) && (run_cnt_q == TIMEOUT_LAST);
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        drain_cnt_d = drain_cnt_q;
        pending_d   = pending_q;
        forced_d    = forced_q;
        tout_d      = tout_q;
        cyc_d       = (sync_rst_n && state_q != S_DONE && cyc_q != '1) ? cyc_q + CNT_WIDTH'(1) : cyc_q;
        case (state_q)
            S_RESET: begin
                pending_d = pending_q | finish_req;
                // Leave RESET on the same edge that sync_rst_n rises, so HOLD spans exactly HOLD_CYCLES edges
                if (sync_q[SYNC_STAGES-2]) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            S_HOLD: begin
                pending_d  = pending_q | finish_req;
                hold_cnt_d = hold_cnt_q + 32'd1;
                if (hold_cnt_q == HOLD_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                // A real request beats a coincident watchdog expiry
                if (finish_req || pending_q || wd_fire) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                    pending_d   = 1'b0;
                    tout_d      = !(finish_req || pending_q);
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 32'd1;
                if (idle_in) begin
                    state_d = S_DONE;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d  = S_DONE;
                    forced_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q      <= '0;
            state_q     <= S_RESET;
            hold_cnt_q  <= '0;
            drain_cnt_q <= '0;
            pending_q   <= 1'b0;
            forced_q    <= 1'b0;
            tout_q      <= 1'b0;
            cyc_q       <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            pending_q   <= pending_d;
            forced_q    <= forced_d;
            tout_q      <= tout_d;
            cyc_q       <= cyc_d;
        end
    end

    // Outputs decode straight from registered state, so they clear asynchronously with RST_N
    assign rst_n_out    = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_DONE);
    assign quiesce      = (state_q == S_DRAIN) || (state_q == S_DONE);
    assign finish_out   = (state_q == S_DONE);
    assign drain_forced = forced_q;
    assign timed_out    = tout_q;
    assign cycle_count  = cyc_q;
    assign state        = state_q;
endmodule

// File: tb/tb_xsim_run_control.sv
// tb_xsim_run_control: randomized bench for xsim_run_control against an event-time reference model.
// The model derives RUN entry, DRAIN entry and DONE edges from the stimulus tables and compares
// {rst_n_out, quiesce, finish_out, drain_forced, timed_out} and cycle_count after every edge.
module tb_xsim_run_control;
    localparam int S     = 2;
    localparam int H     = 20;
    localparam int DC    = 16;
    localparam int T     = 100;
    localparam int R     = S + H;
    localparam int N_MAX = 1100;
    localparam int INF   = 1 << 30;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        finish_req = 1'b0;
    logic        idle_in = 1'b0;
    logic        rst_n_out, quiesce, finish_out, drain_forced, timed_out;
    logic [31:0] cycle_count;
    logic [2:0]  state;

    bit          fr [N_MAX+1];
    bit          id [N_MAX+1];
    logic [4:0]  obs_f [N_MAX+1];
    logic [4:0]  exp_f [N_MAX+1];
    logic [31:0] obs_c [N_MAX+1];
    logic [31:0] exp_c [N_MAX+1];
    int          vectors = 0;
    int          miscompares = 0;

    xsim_run_control #(
        .SYNC_STAGES(S), .HOLD_CYCLES(H), .DRAIN_CYCLES(DC), .CNT_WIDTH(32), .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .finish_req(finish_req), .idle_in(idle_in),
        .rst_n_out(rst_n_out), .quiesce(quiesce), .finish_out(finish_out),
        .drain_forced(drain_forced), .timed_out(timed_out),
        .cycle_count(cycle_count), .state(state)
    );

    always #5 CLK = ~CLK;

    task automatic clear_stim();
        for (int k = 0; k <= N_MAX; k++) begin
            fr[k] = 1'b0;
            id[k] = 1'b0;
        end
    endtask

    task automatic reset_dut();
        @(posedge CLK);
        #3 RST_N = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
    endtask

    // Releases RST_N, then drives fr[k]/id[k] so they are sampled at edge k, recording outputs after each edge
    task automatic apply(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge CLK);
            if (k == 1) RST_N = 1'b1;
            finish_req = fr[k];
            idle_in    = id[k];
            @(posedge CLK);
            #1;
            obs_f[k] = {rst_n_out, quiesce, finish_out, drain_forced, timed_out};
            obs_c[k] = cycle_count;
        end
        @(negedge CLK);
        finish_req = 1'b0;
        idle_in    = 1'b0;
    endtask

    // Event model: RUN begins at edge R; DRAIN at max(first request, R+1) (or R+T on watchdog);
    // DONE at the first idle edge within DC edges of DRAIN, else DC edges after DRAIN entry.
    task automatic compute(input int n);
        int  d, e;
        bit  tout, forced;
        d = INF;
        e = INF;
        tout = 1'b0;
        forced = 1'b0;
        for (int k = 1; k <= n; k++)
            if (fr[k]) begin
                d = (k > R) ? k : R + 1;
                break;
            end
`ifdef XSIM_RUN_CONTROL_TIMEOUT_EN
        if (d > R + T) begin
            d = R + T;
            tout = 1'b1;
        end
`endif
        if (d != INF) begin
            e = d + DC;
            forced = 1'b1;
            for (int k = d + 1; k <= d + DC && k <= N_MAX; k++)
                if (id[k]) begin
                    e = k;
                    forced = 1'b0;
                    break;
                end
        end
        for (int k = 1; k <= n; k++) begin
            exp_f[k] = {k >= R, k >= d, k >= e, forced && k >= e, tout && k >= d};
            exp_c[k] = (k < S) ? 32'd0 : 32'(((k < e) ? k : e) - S);
        end
    endtask

    task automatic test_reset();
        int n;
        n = 40;
        @(posedge CLK);
        #3 RST_N = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            finish_req = 1'($urandom_range(0, 1));
            idle_in    = 1'($urandom_range(0, 1));
            @(posedge CLK);
            #1;
            vectors++;
            if ({rst_n_out, quiesce, finish_out, drain_forced, timed_out} !== 5'b0 || cycle_count !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: got flags=%b count=%0d, want flags=00000 count=0", c,
                         {rst_n_out, quiesce, finish_out, drain_forced, timed_out}, cycle_count);
            end
        end
        clear_stim();
        apply(n);
        compute(n);
        for (int k = 1; k <= n; k++) begin
            vectors++;
            if (obs_f[k] !== exp_f[k] || obs_c[k] !== exp_c[k]) begin
                miscompares++;
                $display("FAIL reset_release edge %0d: got flags=%b count=%0d, want flags=%b count=%0d",
                         k, obs_f[k], obs_c[k], exp_f[k], exp_c[k]);
            end
        end
        vectors++;
        if (obs_f[R-1][4] !== 1'b0 || obs_f[R][4] !== 1'b1 || obs_c[R] !== 32'd20) begin
            miscompares++;
            $display("FAIL reset_release_edge22: got rst_n_out %b->%b count=%0d, want 0->1 count=20",
                     obs_f[R-1][4], obs_f[R][4], obs_c[R]);
        end
    endtask

    task automatic test_clean_finish();
        int f, n;
        reset_dut();
        clear_stim();
        f = $urandom_range(R + 1, R + 20);
        for (int k = 1; k <= f; k++) id[k] = 1'($urandom_range(0, 1));
        fr[f] = 1'b1;
        id[f+3] = 1'b1;
        n = f + 10;
        apply(n);
        compute(n);
        for (int k = 1; k <= n; k++) begin
            vectors++;
            if (obs_f[k] !== exp_f[k] || obs_c[k] !== exp_c[k]) begin
                miscompares++;
                $display("FAIL clean_finish edge %0d: got flags=%b count=%0d, want flags=%b count=%0d",
                         k, obs_f[k], obs_c[k], exp_f[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_forced_drain();
        int f, n;
        for (int pass = 0; pass < 2; pass++) begin
            reset_dut();
            clear_stim();
            f = $urandom_range(R + 1, R + 15);
            fr[f] = 1'b1;
            if (pass == 1) id[f+DC] = 1'b1;
            n = f + DC + 5;
            apply(n);
            compute(n);
            for (int k = 1; k <= n; k++) begin
                vectors++;
                if (obs_f[k] !== exp_f[k] || obs_c[k] !== exp_c[k]) begin
                    miscompares++;
                    $display("FAIL forced_drain%0d edge %0d: got flags=%b count=%0d, want flags=%b count=%0d",
                             pass, k, obs_f[k], obs_c[k], exp_f[k], exp_c[k]);
                end
            end
        end
    endtask

    task automatic test_early_request();
        int n;
        reset_dut();
        clear_stim();
        fr[$urandom_range(S + 1, R)] = 1'b1;
        for (int k = R + 2; k <= R + 30; k++) id[k] = ($urandom_range(0, 3) == 0);
        n = R + 30;
        apply(n);
        compute(n);
        for (int k = 1; k <= n; k++) begin
            vectors++;
            if (obs_f[k] !== exp_f[k] || obs_c[k] !== exp_c[k]) begin
                miscompares++;
                $display("FAIL early_request edge %0d: got flags=%b count=%0d, want flags=%b count=%0d",
                         k, obs_f[k], obs_c[k], exp_f[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_mid_drain_reset();
        int f, n;
        reset_dut();
        clear_stim();
        f = $urandom_range(R + 1, R + 10);
        fr[f] = 1'b1;
        apply(f + 5);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        vectors++;
        if ({rst_n_out, quiesce, finish_out, drain_forced, timed_out} !== 5'b0 || cycle_count !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_drain_async_clear: got flags=%b count=%0d, want flags=00000 count=0",
                     {rst_n_out, quiesce, finish_out, drain_forced, timed_out}, cycle_count);
        end
        repeat (4) @(posedge CLK);
        #1;
        clear_stim();
        n = R + 10;
        apply(n);
        compute(n);
        for (int k = 1; k <= n; k++) begin
            vectors++;
            if (obs_f[k] !== exp_f[k] || obs_c[k] !== exp_c[k]) begin
                miscompares++;
                $display("FAIL mid_drain_restart edge %0d: got flags=%b count=%0d, want flags=%b count=%0d",
                         k, obs_f[k], obs_c[k], exp_f[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_watchdog();
        int n;
        reset_dut();
        clear_stim();
`ifdef XSIM_RUN_CONTROL_TIMEOUT_EN
        n = R + T + DC + 5;
`else
        n = R + 1000;
`endif
        apply(n);
        compute(n);
        for (int k = 1; k <= n; k++) begin
            vectors++;
            if (obs_f[k] !== exp_f[k] || obs_c[k] !== exp_c[k]) begin
                miscompares++;
                $display("FAIL watchdog edge %0d: got flags=%b count=%0d, want flags=%b count=%0d",
                         k, obs_f[k], obs_c[k], exp_f[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 6; it++) begin
            reset_dut();
            clear_stim();
            n = $urandom_range(40, 100);
            for (int k = 1; k <= n; k++) begin
                fr[k] = ($urandom_range(0, 29) == 0);
                id[k] = ($urandom_range(0, 5) == 0);
            end
            apply(n);
            compute(n);
            for (int k = 1; k <= n; k++) begin
                vectors++;
                if (obs_f[k] !== exp_f[k] || obs_c[k] !== exp_c[k]) begin
                    miscompares++;
                    $display("FAIL random%0d edge %0d: got flags=%b count=%0d, want flags=%b count=%0d",
                             it, k, obs_f[k], obs_c[k], exp_f[k], exp_c[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_finish();
        test_forced_drain();
        test_early_request();
        test_mid_drain_reset();
        test_watchdog();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
